// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: receive-side CRC-32, length and PHY-error checker.
// Strips the trailing 4-byte FCS and keeps saturating frame statistics.
module eth_rx_fcs_check #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  mac_clk,
    input  logic                  mac_rst_n,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error,
    output logic [STAT_WIDTH-1:0] stat_ok,
    output logic [STAT_WIDTH-1:0] stat_crc_err,
    output logic [STAT_WIDTH-1:0] stat_len_err,
    output logic [STAT_WIDTH-1:0] stat_phy_err,
    output logic [STAT_WIDTH-1:0] stat_abort
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;

    localparam int CW = $clog2(MAX_FRAME + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME + 1);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic [1:0]                 state;
    logic [3:0][DATA_WIDTH-1:0] dly;
    logic [CW-1:0]              cnt;
    logic [31:0]                crc;
    logic                       phy;
    logic                       first;

    logic [31:0]   crc_seed;
    logic [31:0]   crc_next;
    logic [CW-1:0] cnt_next;
    logic          phy_next;
    logic          len_bad;
    logic          crc_bad;
    logic          frame_bad;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i])
                r = (r >> 1) ^ 32'hEDB88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(
        input logic [STAT_WIDTH-1:0] v
    );
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    // The eop byte is folded in combinationally so the verdict lands with it.
    always_comb begin
        crc_seed  = crc_byte(32'hFFFFFFFF, in_data[7:0]);
        crc_next  = crc_byte(crc, in_data[7:0]);
        cnt_next  = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
        phy_next  = phy | in_error;
        len_bad   = (cnt_next < CW'(MIN_FRAME)) ||
                    (cnt_next > CW'(MAX_FRAME));
        crc_bad   = (crc_next != RESIDUE);
        frame_bad = phy_next | len_bad | crc_bad;
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state             <= S_IDLE;
            dly               <= '0;
            cnt               <= '0;
            crc               <= 32'hFFFFFFFF;
            phy               <= 1'b0;
            first             <= 1'b0;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
            out_data          <= '0;
            stat_ok           <= '0;
            stat_crc_err      <= '0;
            stat_len_err      <= '0;
            stat_phy_err      <= '0;
            stat_abort        <= '0;
        end else begin
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
            if (in_valid) begin
                if (in_startofpacket || state != S_IDLE)
                    dly <= {dly[2:0], in_data};
                if (state == S_PASS) begin
                    out_valid         <= 1'b1;
                    out_data          <= dly[3];
                    out_startofpacket <= first;
                    first             <= 1'b0;
                end
                if (in_startofpacket) begin
                    // Any sop restarts; a sop+eop beat is itself too short.
                    if (state == S_PASS) begin
                        out_endofpacket <= 1'b1;
                        out_error       <= 1'b1;
                    end
                    if (state != S_IDLE || in_endofpacket)
                        stat_abort <= sat_inc(stat_abort);
                    cnt   <= CW'(1);
                    crc   <= crc_seed;
                    phy   <= in_error;
                    first <= 1'b1;
                    state <= in_endofpacket ? S_IDLE : S_FILL;
                end else if (state != S_IDLE) begin
                    cnt <= cnt_next;
                    crc <= crc_next;
                    phy <= phy_next;
                    if (in_endofpacket) begin
                        state <= S_IDLE;
                        if (state == S_FILL) begin
                            stat_abort <= sat_inc(stat_abort);
                        end else begin
                            out_endofpacket <= 1'b1;
                            out_error       <= frame_bad;
                            if (phy_next)
                                stat_phy_err <= sat_inc(stat_phy_err);
                            else if (len_bad)
                                stat_len_err <= sat_inc(stat_len_err);
                            else if (crc_bad)
                                stat_crc_err <= sat_inc(stat_crc_err);
                            else
                                stat_ok <= sat_inc(stat_ok);
                        end
                    end else if (state == S_FILL && cnt == CW'(3)) begin
                        state <= S_PASS;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frames into two checker instances.
// Instance a uses MIN_FRAME=64, instance b uses MIN_FRAME=13.
module tb_eth_rx_fcs_check;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_sop, in_eop, in_valid, in_err;
    logic [7:0]  in_data;

    logic        a_sop, a_eop, a_valid, a_err;
    logic [7:0]  a_data;
    logic [31:0] a_ok, a_crc, a_len, a_phy, a_abt;
    logic        b_sop, b_eop, b_valid, b_err;
    logic [7:0]  b_data;
    logic [31:0] b_ok, b_crc, b_len, b_phy, b_abt;

    always #5 clk = ~clk;

    eth_rx_fcs_check dut_a (
        .mac_clk(clk), .mac_rst_n(rst_n),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_valid(in_valid), .in_data(in_data), .in_error(in_err),
        .out_startofpacket(a_sop), .out_endofpacket(a_eop),
        .out_valid(a_valid), .out_data(a_data), .out_error(a_err),
        .stat_ok(a_ok), .stat_crc_err(a_crc), .stat_len_err(a_len),
        .stat_phy_err(a_phy), .stat_abort(a_abt)
    );

    eth_rx_fcs_check #(.MIN_FRAME(13)) dut_b (
        .mac_clk(clk), .mac_rst_n(rst_n),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_valid(in_valid), .in_data(in_data), .in_error(in_err),
        .out_startofpacket(b_sop), .out_endofpacket(b_eop),
        .out_valid(b_valid), .out_data(b_data), .out_error(b_err),
        .stat_ok(b_ok), .stat_crc_err(b_crc), .stat_len_err(b_len),
        .stat_phy_err(b_phy), .stat_abort(b_abt)
    );

    typedef struct packed {
        logic [31:0] t;
        logic [7:0]  d;
        logic        s;
        logic        e;
        logic        x;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    beat_t       exp_q[$];
    logic [7:0]  frm[$];
    logic [31:0] stamp[$];
    logic [31:0] cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_valid) qa.push_back({cyc, a_data, a_sop, a_eop, a_err});
            if (b_valid) qb.push_back({cyc, b_data, b_sop, b_eop, b_err});
        end
    end

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {24'd0, frm[k]};
            for (int i = 0; i < 8; i++)
                c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'd0);
        end
        return c;
    endfunction

    task automatic mk_frame(input int len);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < len - 4; i++) frm.push_back(8'(i));
        f = ~ref_crc(len - 4);
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    task automatic add_exp(input int n, input logic err);
        for (int k = 0; k < n; k++)
            exp_q.push_back({32'd0, frm[k], k == 0, k == n - 1,
                             (k == n - 1) & err});
    endtask

    function automatic int scan(input bit useb);
        beat_t g;
        int    n;
        int    ne;
        n  = useb ? int'(qb.size()) : int'(qa.size());
        ne = int'(exp_q.size());
        for (int k = 0; k < n && k < ne; k++) begin
            g = useb ? qb[k] : qa[k];
            if ({g.d, g.s, g.e, g.x} !==
                {exp_q[k].d, exp_q[k].s, exp_q[k].e, exp_q[k].x})
                return k;
        end
        if (n != ne) return (n < ne) ? n : ne;
        return -1;
    endfunction

    task automatic send(input int start, input int n, input bit gaps,
                        input int err_idx);
        for (int k = start; k < start + n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0;
                end
            end
            @(negedge clk);
            in_valid = 1;
            in_data  = frm[k];
            in_sop   = (k == 0);
            in_eop   = (k == int'(frm.size()) - 1);
            in_err   = (k == err_idx);
            stamp.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0;
        end
    endtask

    task automatic do_reset();
        in_valid = 0; in_sop = 0; in_eop = 0; in_err = 0; in_data = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        qa.delete(); qb.delete(); exp_q.delete(); stamp.delete();
    endtask

    task automatic test_reset();
        rst_n = 1;
        do_reset();
        total++;
        if ({a_valid, a_sop, a_eop, a_err, a_data} !== 12'd0) begin
            bad++;
            $display("FAIL reset_out got=%h want=0",
                     {a_valid, a_sop, a_eop, a_err, a_data});
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !== 160'd0) begin
            bad++;
            $display("FAIL reset_stats got=%h want=0",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
        mk_frame(64);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1; in_sop = 0; in_eop = 0; in_data = frm[k];
        end
        idle(6);
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL idle_no_sop got=%0d want=0", qa.size());
        end
    endtask

    task automatic test_good64();
        int lat_bad;
        do_reset();
        mk_frame(64);
        send(0, 64, 0, -1);
        idle(4);
        add_exp(60, 1'b0);
        total++;
        if (qa.size() != 60) begin
            bad++;
            $display("FAIL good64_count got=%0d want=60", qa.size());
        end
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL good64_stream got_idx=%0d want=-1", scan(0));
        end
        lat_bad = -1;
        for (int k = 0; k < qa.size() && k + 4 < stamp.size(); k++)
            if (lat_bad < 0 && qa[k].t !== stamp[k + 4] + 1) lat_bad = k;
        total++;
        if (lat_bad !== -1) begin
            bad++;
            $display("FAIL good64_latency got_idx=%0d want=-1", lat_bad);
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd1, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL good64_stats got=%h want ok=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
    endtask

    task automatic test_check_value();
        logic [7:0] v [13];
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
              8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        do_reset();
        frm.delete();
        for (int k = 0; k < 13; k++) frm.push_back(v[k]);
        send(0, 13, 0, -1);
        idle(4);
        add_exp(9, 1'b1);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL cv_min64_stream got_idx=%0d want=-1", scan(0));
        end
        exp_q.delete();
        add_exp(9, 1'b0);
        total++;
        if (scan(1) !== -1) begin
            bad++;
            $display("FAIL cv_min13_stream got_idx=%0d want=-1", scan(1));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd0, 32'd0, 32'd1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL cv_min64_stats got=%h want len=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
        total++;
        if ({b_ok, b_crc, b_len, b_phy, b_abt} !==
            {32'd1, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL cv_min13_stats got=%h want ok=1",
                     {b_ok, b_crc, b_len, b_phy, b_abt});
        end
    endtask

    task automatic test_crc_phy();
        do_reset();
        mk_frame(64);
        frm[63] = frm[63] ^ 8'h01;
        send(0, 64, 0, -1);
        idle(4);
        add_exp(60, 1'b1);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL crc_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd0, 32'd1, 32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL crc_stats got=%h want crc=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
        do_reset();
        mk_frame(64);
        send(0, 64, 0, 10);
        idle(4);
        add_exp(60, 1'b1);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL phy_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd0, 32'd0, 32'd0, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL phy_stats got=%h want phy=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
    endtask

    task automatic test_oversize();
        do_reset();
        mk_frame(1519);
        send(0, 1519, 0, -1);
        idle(4);
        add_exp(1515, 1'b1);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL over1519_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd0, 32'd0, 32'd1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL over1519_stats got=%h want len=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
        do_reset();
        mk_frame(1518);
        send(0, 1518, 0, -1);
        idle(4);
        add_exp(1514, 1'b0);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL max1518_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd1, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL max1518_stats got=%h want ok=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mk_frame(64);
        send(0, 19, 0, -1);
        send(0, 64, 0, -1);
        idle(4);
        add_exp(16, 1'b1);
        add_exp(60, 1'b0);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL abort_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !==
            {32'd1, 32'd0, 32'd0, 32'd0, 32'd1}) begin
            bad++;
            $display("FAIL abort_stats got=%h want ok=1 abort=1",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
        frm.delete();
        frm.push_back(8'hA1); frm.push_back(8'hB2); frm.push_back(8'hC3);
        send(0, 3, 0, -1);
        idle(6);
        total++;
        if (qa.size() != 76) begin
            bad++;
            $display("FAIL short3_no_out got=%0d want=76", qa.size());
        end
        total++;
        if (a_abt !== 32'd2) begin
            bad++;
            $display("FAIL short3_abort got=%0d want=2", a_abt);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        mk_frame(64);
        send(0, 64, 1, -1);
        idle(4);
        add_exp(60, 1'b0);
        total++;
        if (scan(0) !== -1) begin
            bad++;
            $display("FAIL gaps_stream got_idx=%0d want=-1", scan(0));
        end
        total++;
        if (a_ok !== 32'd1) begin
            bad++;
            $display("FAIL gaps_ok got=%0d want=1", a_ok);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mk_frame(64);
        send(0, 64, 0, -1);
        idle(2);
        send(0, 30, 0, -1);
        @(posedge clk);
        #2;
        total++;
        if ({a_valid, a_ok} !== {1'b1, 32'd1}) begin
            bad++;
            $display("FAIL midrst_pre got=%h want=100000001",
                     {a_valid, a_ok});
        end
        rst_n = 0;
        #1;
        total++;
        if ({a_valid, a_sop, a_eop, a_err, a_data, a_ok} !== 44'd0) begin
            bad++;
            $display("FAIL midrst_async got=%h want=0",
                     {a_valid, a_sop, a_eop, a_err, a_data, a_ok});
        end
        @(negedge clk);
        rst_n = 1;
        qa.delete();
        send(30, 34, 0, -1);
        idle(6);
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL midrst_no_out got=%0d want=0", qa.size());
        end
        total++;
        if ({a_ok, a_crc, a_len, a_phy, a_abt} !== 160'd0) begin
            bad++;
            $display("FAIL midrst_stats got=%h want=0",
                     {a_ok, a_crc, a_len, a_phy, a_abt});
        end
    endtask

    initial begin
        test_reset();
        test_good64();
        test_check_value();
        test_crc_phy();
        test_oversize();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
